// File: rtl/det_window_counter.sv
// det_window_counter
// Counts detections from the Moore sequence detector over a programmable
// window of cycles, then publishes the count, a saturation flag, an any-hit
// flag and the window offset of the first hit.
module det_window_counter #(
   parameter int CNT_W     = 8,
   parameter int WIN_W     = 16,
   parameter int EDGE_MODE = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             det_in,
   input  logic             start,
   input  logic [WIN_W-1:0] win_len,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] count,
   output logic             overflow,
   output logic             hit,
   output logic [WIN_W-1:0] first_pos
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] COUNT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);

   logic [1:0]       state;
   logic [1:0]       nextState;
   logic [WIN_W-1:0] winLenQ;
   logic [WIN_W-1:0] timer;
   logic             detQ;
   logic [CNT_W-1:0] accCount;
   logic             accOverflow;
   logic             accHit;
   logic [WIN_W-1:0] accFirst;
   logic             accept;
   logic             lastCycle;
   logic             ev;

   // Start is only honoured in IDLE; the last window cycle is found by a
   // full-width compare against the captured length minus one.
   assign accept    = (state == IDLE) && start;
   assign lastCycle = (timer == (winLenQ - WIN_ONE));
   assign ev        = (EDGE_MODE != 0) ? (det_in & ~detQ) : det_in;

   // Next-state selection: zero-length windows skip straight to DONE.
   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (start) begin
               nextState = (win_len != '0) ? COUNT : DONE;
            end
         end
         COUNT: begin
            if (lastCycle) begin
               nextState = DONE;
            end
         end
         DONE: begin
            nextState = IDLE;
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // State register with registered busy and a done pulse issued as DONE ends.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= nextState;
         busy  <= (nextState == COUNT);
         done  <= (state == DONE);
      end
   end

   // Delayed copy of det_in, kept running in every state for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         detQ <= 1'b0;
      end else begin
         detQ <= det_in;
      end
   end

   // Window length capture and window offset timer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         winLenQ <= '0;
         timer   <= '0;
      end else if (accept) begin
         winLenQ <= win_len;
         timer   <= '0;
      end else if (state == COUNT) begin
         timer <= timer + WIN_ONE;
      end
   end

   // Accumulators: saturating count, overflow, first-hit flag and position.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         accCount    <= '0;
         accOverflow <= 1'b0;
         accHit      <= 1'b0;
         accFirst    <= '0;
      end else if (accept) begin
         accCount    <= '0;
         accOverflow <= 1'b0;
         accHit      <= 1'b0;
         accFirst    <= '0;
      end else if ((state == COUNT) && ev) begin
         if (accCount < CNT_MAX) begin
            accCount <= accCount + CNT_ONE;
         end else begin
            accOverflow <= 1'b1;
         end
         if (!accHit) begin
            accHit   <= 1'b1;
            accFirst <= timer;
         end
      end
   end

   // Published results, refreshed only when a window completes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count     <= '0;
         overflow  <= 1'b0;
         hit       <= 1'b0;
         first_pos <= '0;
      end else if (state == DONE) begin
         count     <= accCount;
         overflow  <= accOverflow;
         hit       <= accHit;
         first_pos <= accFirst;
      end
   end

endmodule

// File: tb/tb_det_window_counter.sv
// Testbench for det_window_counter: three instances (level mode, edge mode,
// 3-bit saturating counter) share one stimulus stream; expected results come
// from a reference model and are queued until each done pulse.
module tb_det_window_counter;

   logic        clk = 1'b0;
   logic        rst;
   logic        det_in;
   logic        start;
   logic [15:0] win_len;

   logic        busy0, done0, overflow0, hit0;
   logic [7:0]  count0;
   logic [15:0] firstPos0;
   logic        busy1, done1, overflow1, hit1;
   logic [7:0]  count1;
   logic [15:0] firstPos1;
   logic        busy2, done2, overflow2, hit2;
   logic [2:0]  count2;
   logic [15:0] firstPos2;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [2:0][7:0]  cnt;
      logic [2:0]       ovf;
      logic [2:0]       hit;
      logic [2:0][15:0] first;
   } exp_t;

   exp_t sbQueue[$];

   det_window_counter #(.CNT_W(8), .WIN_W(16), .EDGE_MODE(0)) dut0 (
      .clk(clk), .rst(rst), .det_in(det_in), .start(start), .win_len(win_len),
      .busy(busy0), .done(done0), .count(count0), .overflow(overflow0),
      .hit(hit0), .first_pos(firstPos0)
   );

   det_window_counter #(.CNT_W(8), .WIN_W(16), .EDGE_MODE(1)) dut1 (
      .clk(clk), .rst(rst), .det_in(det_in), .start(start), .win_len(win_len),
      .busy(busy1), .done(done1), .count(count1), .overflow(overflow1),
      .hit(hit1), .first_pos(firstPos1)
   );

   det_window_counter #(.CNT_W(3), .WIN_W(16), .EDGE_MODE(0)) dut2 (
      .clk(clk), .rst(rst), .det_in(det_in), .start(start), .win_len(win_len),
      .busy(busy2), .done(done2), .count(count2), .overflow(overflow2),
      .hit(hit2), .first_pos(firstPos2)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Reference model: walk the per-offset det_in pattern for each instance.
   function automatic exp_t model(input int len, input logic [31:0] pat, input logic pre);
      exp_t e;
      e = '0;
      for (int c = 0; c < 3; c++) begin
         logic prev;
         logic lvl;
         logic evt;
         int   maxCnt;
         prev   = pre;
         maxCnt = (c == 2) ? 7 : 255;
         for (int k = 0; k < len; k++) begin
            lvl  = pat[k];
            evt  = (c == 1) ? (lvl & ~prev) : lvl;
            prev = lvl;
            if (evt) begin
               if (!e.hit[c]) begin
                  e.hit[c]   = 1'b1;
                  e.first[c] = 16'(k);
               end
               if (int'(e.cnt[c]) < maxCnt) begin
                  e.cnt[c] = e.cnt[c] + 8'd1;
               end else begin
                  e.ovf[c] = 1'b1;
               end
            end
         end
      end
      return e;
   endfunction

   // Single comparison point.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Accept a window and drive its det_in pattern; optionally pulse start mid-window.
   task automatic applyStimulus(input int len, input logic [31:0] pat, input logic pre,
                                input bit spurious);
      det_in  = pre;
      win_len = 16'(len);
      start   = 1'b1;
      sbQueue.push_back(model(len, pat, pre));
      @(posedge clk); #1;
      start   = 1'b0;
      win_len = 16'd3;
      if (len == 0) begin
         checkOutput("busy_zero_len", 32'(busy0), 32'd0);
      end
      for (int k = 0; k < len; k++) begin
         det_in = pat[k];
         if (k == 0) begin
            checkOutput("busy_in_window", 32'(busy0), 32'd1);
         end
         start = spurious && (k == 1);
         if (k < len - 1) begin
            @(posedge clk); #1;
         end
      end
      start = 1'b0;
   endtask

   // Wait (bounded) for done, check latency, pop the scoreboard and compare.
   task automatic awaitResult(input int len, input bit spurious);
      int   cyc;
      bit   seen;
      exp_t e;
      cyc  = (len == 0) ? 0 : len - 1;
      seen = 1'b0;
      for (int i = 0; i < len + 20 && !seen; i++) begin
         @(posedge clk); #1;
         cyc++;
         det_in = 1'b0;
         start  = spurious && (cyc == len);
         if (done0) seen = 1'b1;
      end
      start = 1'b0;
      checkOutput("done_seen", 32'(seen), 32'd1);
      checkOutput("done_latency", 32'(cyc), 32'(len + 1));
      if (seen && sbQueue.size() > 0) begin
         e = sbQueue.pop_front();
         checkOutput("done1_aligned", 32'(done1), 32'd1);
         checkOutput("done2_aligned", 32'(done2), 32'd1);
         checkOutput("busy_after_done", 32'(busy0), 32'd0);
         checkOutput("count_lvl", 32'(count0), 32'(e.cnt[0]));
         checkOutput("ovf_lvl", 32'(overflow0), 32'(e.ovf[0]));
         checkOutput("hit_lvl", 32'(hit0), 32'(e.hit[0]));
         checkOutput("first_lvl", 32'(firstPos0), 32'(e.first[0]));
         checkOutput("count_edge", 32'(count1), 32'(e.cnt[1]));
         checkOutput("ovf_edge", 32'(overflow1), 32'(e.ovf[1]));
         checkOutput("hit_edge", 32'(hit1), 32'(e.hit[1]));
         checkOutput("first_edge", 32'(firstPos1), 32'(e.first[1]));
         checkOutput("count_sat", 32'(count2), 32'(e.cnt[2]));
         checkOutput("ovf_sat", 32'(overflow2), 32'(e.ovf[2]));
         checkOutput("hit_sat", 32'(hit2), 32'(e.hit[2]));
         checkOutput("first_sat", 32'(firstPos2), 32'(e.first[2]));
      end else if (sbQueue.size() > 0) begin
         void'(sbQueue.pop_front());
      end
      if (spurious) begin
         @(posedge clk); #1;
         checkOutput("start_ignored_busy", 32'(busy0), 32'd0);
         checkOutput("start_ignored_done", 32'(done0), 32'd0);
      end
   endtask

   // Directed sequence of scenarios.
   initial begin
      int doneCount;
      int rlen;
      logic [31:0] rpat;

      rst     = 1'b1;
      det_in  = 1'b0;
      start   = 1'b0;
      win_len = 16'd0;
      #12;
      checkOutput("reset_busy", 32'(busy0), 32'd0);
      checkOutput("reset_done", 32'(done0), 32'd0);
      checkOutput("reset_count", 32'(count0), 32'd0);
      checkOutput("reset_ovf", 32'(overflow0), 32'd0);
      checkOutput("reset_hit", 32'(hit0), 32'd0);
      checkOutput("reset_first", 32'(firstPos0), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;

      // Basic count: hits at offsets 2, 3, 7.
      applyStimulus(10, 32'h0000_008C, 1'b0, 1'b0);
      awaitResult(10, 1'b0);

      // Reset at window cycle 5 aborts the window and clears results.
      det_in  = 1'b0;
      win_len = 16'd20;
      start   = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < 5; k++) begin
         det_in = 1'b1;
         @(posedge clk); #1;
      end
      rst = 1'b1;
      #1;
      checkOutput("abort_busy", 32'(busy0), 32'd0);
      checkOutput("abort_done", 32'(done0), 32'd0);
      checkOutput("abort_count", 32'(count0), 32'd0);
      checkOutput("abort_hit", 32'(hit0), 32'd0);
      checkOutput("abort_first", 32'(firstPos0), 32'd0);
      det_in = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      doneCount = 0;
      for (int i = 0; i < 25; i++) begin
         @(posedge clk); #1;
         if (done0 || busy0) doneCount++;
      end
      checkOutput("abort_no_done", 32'(doneCount), 32'd0);

      // Edge mode: level high before start through offset 4, then 6..8.
      applyStimulus(10, 32'h0000_01DF, 1'b1, 1'b0);
      awaitResult(10, 1'b0);

      // Saturation: det_in high for all 12 cycles.
      applyStimulus(12, 32'h0000_0FFF, 1'b0, 1'b0);
      awaitResult(12, 1'b0);

      // Zero-length window.
      applyStimulus(0, 32'h0, 1'b0, 1'b0);
      awaitResult(0, 1'b0);

      // One-cycle window with a hit at offset 0.
      applyStimulus(1, 32'h1, 1'b0, 1'b0);
      awaitResult(1, 1'b0);

      // Hit only on the last window cycle.
      applyStimulus(5, 32'h10, 1'b0, 1'b0);
      awaitResult(5, 1'b0);

      // Start pulses during COUNT and DONE are ignored.
      applyStimulus(8, 32'h22, 1'b0, 1'b1);
      awaitResult(8, 1'b1);

      // Back-to-back: second start lands in the done cycle; no-hit window overwrites.
      applyStimulus(6, 32'h0C, 1'b0, 1'b0);
      awaitResult(6, 1'b0);
      applyStimulus(6, 32'h0, 1'b1, 1'b0);
      awaitResult(6, 1'b0);

      // A few random windows.
      for (int r = 0; r < 4; r++) begin
         rlen = int'($urandom_range(20, 1));
         rpat = $urandom;
         applyStimulus(rlen, rpat, 1'($urandom_range(1, 0)), 1'b0);
         awaitResult(rlen, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/det_window_counter.md
Name: det_window_counter

Overview:
- Downstream consumer of the Moore sequence-detector output.
- Counts detections on `det_in` over a programmable observation window, then latches a result: count, saturation flag, any-hit flag and cycle offset of the first hit.
- Results go to the status/readout logic.
- Single clock domain, same clock as the detector.

Parameters:
- CNT_W, 8, width of the detection counter (saturating).
- WIN_W, 16, width of the window length and position fields.
- EDGE_MODE, 0, 0 = count every cycle `det_in`=1 (overlapping Moore hits); 1 = count only 0->1 transitions of `det_in`.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- det_in  input  1  detector output (`out` of the Moore FSM), synchronous to clk.
- start  input  1  request to open a window; sampled only in IDLE.
- win_len  input  WIN_W  window length in cycles; captured when start is accepted.
- busy  output  1  high while a window is open (COUNT state).
- done  output  1  one-cycle pulse when results are updated.
- count  output  CNT_W  detections in the last completed window.
- overflow  output  1  a detection occurred while the internal count was already at max.
- hit  output  1  at least one detection in the last window.
- first_pos  output  WIN_W  window offset (0-based) of the first counted detection; 0 if hit=0.

Behaviour:
- Reset:
  - Clock and reset ports are `clk` and `rst`; one clock; reset is asynchronous and active-high.
  - rst=1 forces state IDLE and internal counters/timer/`det_q` to 0.
  - Outputs on reset: busy=0, done=0, count=0, overflow=0, hit=0, first_pos=0.
  - Reset mid-window aborts the window: no done pulse, stale results cleared.
- State IDLE:
  - busy=0.
  - start=1 with win_len!=0 captures win_len, clears the internal accumulators and enters COUNT.
  - start=1 with win_len==0 enters DONE directly, so the next cycle publishes count=0, hit=0, overflow=0, first_pos=0.
- State COUNT:
  - busy=1.
  - The window is exactly win_len cycles, beginning the cycle after start is accepted.
  - `timer` runs 0..win_len-1.
  - Each cycle, `ev` is evaluated:
    - EDGE_MODE=0: ev = det_in.
    - EDGE_MODE=1: ev = det_in & ~det_q.
  - On ev=1:
    - If the accumulator < 2^CNT_W-1, increment it.
    - Otherwise hold it and set the internal overflow flag.
    - If this is the first event, set internal hit and record first_pos = timer.
  - When timer == win_len-1, the event in that cycle is still counted and the next state is DONE.
  - start is ignored in COUNT; win_len changes have no effect after capture.
- State DONE, one cycle:
  - Copies the accumulators to the count/overflow/hit/first_pos outputs.
  - done=1 for this cycle only.
  - Returns to IDLE.
  - start is ignored in DONE; the earliest new acceptance is the following IDLE cycle.
- Output latency: done and the updated results appear 1 cycle after the last window cycle. Total is win_len+1 cycles after the start-accept edge.
- Outputs hold their values until the next done; busy/done are registered.
- `det_q` is a register of det_in, updated every cycle in all states.
  - With EDGE_MODE=1, a level already high before the window does not count as an edge in window cycle 0.
- The timer compare uses the full WIN_W width. win_len = 2^WIN_W-1 is legal; there is no wrap inside a window.

Test Plan:
- Reset mid-window: start, win_len=20, assert rst at window cycle 5 -> busy=0 immediately (async), no done pulse, all outputs 0, next start works normally.
- Basic count, EDGE_MODE=0: win_len=10, det_in=1 at offsets 2, 3, 7 -> done pulse 11 cycles after start accept, count=3, hit=1, first_pos=2, overflow=0.
- Edge mode, EDGE_MODE=1: det_in held high from before start through offset 4, low at offset 5, high at offsets 6-8, win_len=10 -> count=1, first_pos=6 (pre-window high not counted).
- Saturation, CNT_W=3: win_len=12, det_in=1 every cycle -> count=7, overflow=1, first_pos=0, hit=1.
- Zero and boundary windows:
  - win_len=0 -> done one cycle after the DONE entry, count=0, hit=0.
  - win_len=1 with det_in=1 at offset 0 -> count=1, first_pos=0.
  - det_in=1 only on the last window cycle (win_len=5, offset 4) -> count=1, first_pos=4.
- Start while busy and back-to-back:
  - start pulses during COUNT and DONE are ignored; results come from the first window only.
  - A start in the first IDLE cycle after done is accepted.
  - A window with no hits publishes hit=0, first_pos=0, and the previous results are overwritten.
